// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard control bundle: pipeline status into the controller,
// register enables/flushes and stall statistics back out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             id_branch_taken;
  logic             id_jump;
  logic             id_uses_hilo;
  logic             ex_muldiv_start;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_wr_en;
  logic             if_id_wr_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_freeze;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rt, id_branch_taken, id_jump,
           id_uses_hilo, ex_muldiv_start, mem_req, mem_ready,
    input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, pipe_freeze,
           muldiv_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rt, id_branch_taken, id_jump,
           id_uses_hilo, ex_muldiv_start, mem_req, mem_ready,
    output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, pipe_freeze,
           muldiv_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: freeze on data-memory wait,
// stall on load-use or HI/LO-while-busy, flush IF/ID on branch/jump redirect.
module hazard_stall_ctrl #(
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input logic           clk,
  input logic           reset,
  hazard_stall_ctrl_if.slave bus
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [7:0]       md_cnt_reg, md_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic freeze, busy, load_use, data_stall, redirect;
  logic pc_wr, ifid_wr, ifid_flush, idex_flush;

  assign freeze     = bus.mem_req & ~bus.mem_ready;
  assign busy       = (md_cnt_reg != 8'd0);
  assign load_use   = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
  assign data_stall = load_use | (busy & bus.id_uses_hilo);
  assign redirect   = bus.id_branch_taken | bus.id_jump;

  // A redirect under a data stall is dropped; the held branch re-resolves.
  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      pc_wr      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else if (data_stall) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
    end else if (redirect) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (freeze) state_next = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Counter keeps running through a freeze; a start seen during a freeze is
  // ignored because EX presents it again once the freeze lifts.
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (bus.ex_muldiv_start && !busy && !freeze)
      md_cnt_next = 8'(MULDIV_CYCLES);
    else if (busy)
      md_cnt_next = md_cnt_reg - 8'd1;
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (!pc_wr && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= RUN;
      md_cnt_reg    <= 8'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      md_cnt_reg    <= md_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign bus.pc_wr_en    = pc_wr;
  assign bus.if_id_wr_en = ifid_wr;
  assign bus.if_id_flush = ifid_flush;
  assign bus.id_ex_flush = idex_flush;
  assign bus.pipe_freeze = reset & freeze;
  assign bus.muldiv_busy = reset & busy;
  assign bus.stall_count = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: directed vectors push hand-derived expected outputs;
// a negedge monitor pops and compares against a 16-bit and a 4-bit counter DUT.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus16 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();

  hazard_stall_ctrl #(.MULDIV_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );
  hazard_stall_ctrl #(.MULDIV_CYCLES(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  assign bus4.id_rs           = bus16.id_rs;
  assign bus4.id_rt           = bus16.id_rt;
  assign bus4.ex_mem_read     = bus16.ex_mem_read;
  assign bus4.ex_rt           = bus16.ex_rt;
  assign bus4.id_branch_taken = bus16.id_branch_taken;
  assign bus4.id_jump         = bus16.id_jump;
  assign bus4.id_uses_hilo    = bus16.id_uses_hilo;
  assign bus4.ex_muldiv_start = bus16.ex_muldiv_start;
  assign bus4.mem_req         = bus16.mem_req;
  assign bus4.mem_ready       = bus16.mem_ready;

  // {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, pipe_freeze, muldiv_busy}
  localparam logic [5:0] RUNO = 6'b110000;
  localparam logic [5:0] STL  = 6'b000100;
  localparam logic [5:0] RED  = 6'b111000;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] RST  = 6'b011100;
  localparam logic [5:0] BSY  = 6'b000001;

  typedef struct {
    logic [5:0] flags;
    int         cnt;
    int         cnt4;
    bit         cnt_ok;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_cnt  = 0;
  int   m_cnt4 = 0;
  bit   m_valid = 1'b0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic [5:0] act;
      mon_e = q.pop_front();
      act = {bus16.pc_wr_en, bus16.if_id_wr_en, bus16.if_id_flush,
             bus16.id_ex_flush, bus16.pipe_freeze, bus16.muldiv_busy};
      n_chk++;
      if (act !== mon_e.flags) begin
        n_fail++;
        $display("FAIL %s flags: got %b required %b", mon_e.name, act, mon_e.flags);
      end
      if (mon_e.cnt_ok) begin
        n_chk++;
        if (bus16.stall_count !== 16'(mon_e.cnt)) begin
          n_fail++;
          $display("FAIL %s stall_count: got %0d required %0d", mon_e.name, bus16.stall_count, mon_e.cnt);
        end
        n_chk++;
        if (bus4.stall_count !== 4'(mon_e.cnt4)) begin
          n_fail++;
          $display("FAIL %s stall_count4: got %0d required %0d", mon_e.name, bus4.stall_count, mon_e.cnt4);
        end
      end
    end
  end

  task automatic step(input string name, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] ert,
                      input logic br, input logic jmp, input logic hilo,
                      input logic mds, input logic mreq, input logic mrdy,
                      input logic [5:0] eo);
    exp_t e;
    @(posedge clk);
    #1;
    reset                 = rst;
    bus16.id_rs           = rs;
    bus16.id_rt           = rt;
    bus16.ex_mem_read     = mr;
    bus16.ex_rt           = ert;
    bus16.id_branch_taken = br;
    bus16.id_jump         = jmp;
    bus16.id_uses_hilo    = hilo;
    bus16.ex_muldiv_start = mds;
    bus16.mem_req         = mreq;
    bus16.mem_ready       = mrdy;
    e.flags  = eo;
    e.cnt    = m_cnt;
    e.cnt4   = m_cnt4;
    e.cnt_ok = m_valid;
    e.name   = name;
    q.push_back(e);
    $display("txn %-10s rst=%b rs=%0d rt=%0d ld=%b ert=%0d br=%b j=%b hilo=%b mds=%b req=%b rdy=%b exp=%b",
             name, rst, rs, rt, mr, ert, br, jmp, hilo, mds, mreq, mrdy, eo);
    if (!rst) begin
      m_cnt = 0; m_cnt4 = 0; m_valid = 1'b1;
    end else if (!eo[5]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic idle(input string name, input logic [5:0] eo);
    step(name, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step("rst0", 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, RST);
    step("rst1", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST);
    idle("idle", RUNO);
    // load-use and the r0 exemption
    step("lu_rs", 1'b1, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    idle("after_lu", RUNO);
    step("lu_r0", 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUNO);
    step("lu_rt", 1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    // redirects, and a redirect masked by a stall
    step("branch", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RED);
    step("jump", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RED);
    step("br_lu", 1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    // mult/div with HI/LO use held; second start at cycle 3 ignored
    step("md_c0", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RUNO);
    for (int i = 1; i <= 8; i++)
      step($sformatf("md_c%0d", i), 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
           (i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, STL | BSY);
    step("md_c9", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUNO);
    // freeze in cycles 2..4 of a mult/div; freeze beats load-use and branch
    step("mdf_c0", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RUNO);
    idle("mdf_c1", RUNO | BSY);
    for (int i = 2; i <= 4; i++)
      step($sformatf("mdf_c%0d", i), 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, FRZ | BSY);
    step("mdf_c5", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RUNO | BSY);
    for (int i = 6; i <= 8; i++) idle($sformatf("mdf_c%0d", i), RUNO | BSY);
    idle("mdf_c9", RUNO);
    // memory wait with a start presented during freeze (must be ignored)
    for (int i = 0; i < 3; i++)
      step($sformatf("mw_%0d", i), 1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, FRZ);
    step("mw_rdy", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RED);
    idle("mw_after", RUNO);
    // reset in cycle 4 of a mult/div, during a memory wait
    step("rmd_c0", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RUNO);
    for (int i = 1; i <= 3; i++) idle($sformatf("rmd_c%0d", i), RUNO | BSY);
    step("rmd_rst", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RST);
    step("rmd_rst2", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST);
    step("rmd_rel", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUNO);
    // 20 stalls: 16-bit counter reaches 20, 4-bit one saturates at 15
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_%0d", i), 1'b1, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, STL);
    idle("sat_end", RUNO);
    idle("sat_end2", RUNO);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
